pump_scheduler: RTL
===================

Name: pump_scheduler

Overview:
- Downstream consumer of the mode controller's one-cycle pump_on and pump_off pulses and of its 2-bit timer selection.
- Runs a timed diffuser session of 30, 60 or 120 minutes. Within the session it drives the pump with a fixed spray/rest duty cycle.
- Exports remaining minutes and seconds, state and a completion pulse for the LCD and status LED logic.

Parameters:
- CLK_HZ, 1_000_000, clk cycles per second tick.
- SEC_PER_MIN, 60, seconds per minute (reduced for simulation); must be 2..64.
- SPRAY_ON_SEC, 5, pump-on seconds at the start of each period; must be 1..SPRAY_PERIOD_SEC-1.
- SPRAY_PERIOD_SEC, 60, length of one spray+rest period in seconds; must be 2..255.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- pump_on  in  1  one-cycle start/restart request
- pump_off  in  1  one-cycle stop request
- timer_sel  in  2  0=30 min, 1=60 min, 2=120 min, 3=30 min
- pump_drive  out  1  pump enable, registered
- active  out  1  session running (SPRAY or REST)
- state  out  2  0=IDLE, 1=SPRAY, 2=REST
- remain_min  out  7  minutes remaining, 0..120
- remain_sec  out  6  seconds remaining within the minute, 0..SEC_PER_MIN-1
- session_done  out  1  one-cycle pulse on natural expiry

Behaviour:
- Reset (async, active-low) forces:
  - state=IDLE; pump_drive, active, session_done = 0
  - remain_min = 0, remain_sec = 0
  - prescaler and phase counter = 0
- Prescaler:
  - Counts 0..CLK_HZ-1 only while active.
  - sec_tick is asserted on the cycle the count equals CLK_HZ-1; the count wraps to 0 that cycle.
  - Cleared on every start or stop.
- Start, when pump_on=1 and pump_off=0 in any state:
  - remain_min <= minutes decoded from timer_sel (30/60/120/30); remain_sec <= 0.
  - Phase counter <= 0, prescaler <= 0, state <= SPRAY.
  - pump_drive and active become 1 on the cycle after the pulse (1-cycle latency).
  - pump_on while already running is a restart: the timer is reloaded from the current timer_sel.
- Stop, when pump_off=1:
  - state <= IDLE; pump_drive and active <= 0 next cycle.
  - remain_min and remain_sec cleared to 0.
  - No session_done pulse.
- pump_off has priority over pump_on in the same cycle.
- timer_sel is sampled only at start; changes mid-session are ignored.
- On each sec_tick while active, in priority order:
  1. Expiry: if remain_min==0 and remain_sec==1 → state <= IDLE, remain_sec <= 0, pump_drive <= 0, session_done <= 1 for exactly one cycle. No further phase update.
  2. Else if remain_sec==0 → remain_min <= remain_min-1, remain_sec <= SEC_PER_MIN-1.
  3. Else remain_sec <= remain_sec-1.
  4. Phase: phase <= (phase==SPRAY_PERIOD_SEC-1) ? 0 : phase+1.
     - SPRAY→REST when the new phase == SPRAY_ON_SEC.
     - REST→SPRAY when the new phase == 0.
- pump_drive = 1 exactly when state==SPRAY (registered together with the state).
- Total session length from start is exactly minutes×SEC_PER_MIN×CLK_HZ cycles ±1.
- Time remaining never underflows; 0:00 is only ever shown in IDLE.
- Arithmetic: unsigned throughout. The phase counter is 8 bits and the prescaler is 20 bits (widen with clog2 of the parameters).
- A reset mid-session aborts immediately; outputs go to their reset values asynchronously.

Test Plan:
- Reset then idle: assert reset low for 3 cycles with pump pulses held off → state=0, pump_drive=0, remain=0:00, no session_done.
- Setup for the remaining tests: CLK_HZ=4, SEC_PER_MIN=4, SPRAY_ON_SEC=2, SPRAY_PERIOD_SEC=5.
- Basic start: timer_sel=0, pump_on pulse → next cycle remain_min=30, remain_sec=0, pump_drive=1. After 8 clk: pump_drive=0, state=2. After 20 clk: pump_drive=1 again. Remain reads 29:3 after the first tick.
- Natural expiry: start, then force the counts to 0:02 → 4 clk later 0:01, 4 clk later state=0, remain 0:00, session_done high exactly 1 cycle, pump_drive=0.
- Stop and priority: mid-REST pulse pump_on and pump_off in the same cycle → state=0, remain 0:00, no session_done. Then pulse pump_on alone → restart in SPRAY.
- Restart and timer_sel sampling: start with timer_sel=2 (120), change timer_sel to 1 → remain_min stays on the 120 count. Pulse pump_on → remain_min=60, phase restarts, pump_drive=1.
- Async reset mid-SPRAY: pull reset low between clock edges → pump_drive=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/pump_scheduler.sv
// pump_scheduler
// Runs a timed diffuser session (30/60/120 minutes) and, inside it, a fixed
// spray/rest duty cycle on the pump. Consumes the one-cycle pump_on/pump_off
// pulses and the timer selection from the mode controller.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low reset
//   pump_on      one-cycle start/restart request
//   pump_off     one-cycle stop request (wins over pump_on)
//   timer_sel    0=30 min, 1=60 min, 2=120 min, 3=30 min (sampled at start)
//   pump_drive   registered pump enable, high exactly in SPRAY
//   active       session running (SPRAY or REST)
//   state        0=IDLE, 1=SPRAY, 2=REST
//   remain_min   minutes remaining, 0..120
//   remain_sec   seconds remaining within the minute
//   session_done one-cycle pulse on natural expiry
module pump_scheduler #(
    parameter int CLK_HZ           = 1_000_000,
    parameter int SEC_PER_MIN      = 60,
    parameter int SPRAY_ON_SEC     = 5,
    parameter int SPRAY_PERIOD_SEC = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pump_on,
    input  logic       pump_off,
    input  logic [1:0] timer_sel,
    output logic       pump_drive,
    output logic       active,
    output logic [1:0] state,
    output logic [6:0] remain_min,
    output logic [5:0] remain_sec,
    output logic       session_done
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPRAY = 2'd1,
        ST_REST  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    phase_q, phase_d;
    logic [6:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          pump_drive_q, pump_drive_d;
    logic          done_q, done_d;

    logic          running;
    logic          sec_tick;
    logic          start;
    logic [7:0]    phase_next;
    logic [6:0]    sel_minutes;

    assign running = (state_q != ST_IDLE);
    assign start   = pump_on & ~pump_off;

    always_comb begin
        case (timer_sel)
            2'd1:    sel_minutes = 7'd60;
            2'd2:    sel_minutes = 7'd120;
            default: sel_minutes = 7'd30;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        phase_d      = phase_q;
        min_d        = min_q;
        sec_d        = sec_q;
        done_d       = 1'b0;
        sec_tick     = 1'b0;
        phase_next   = (phase_q == 8'(SPRAY_PERIOD_SEC - 1)) ? 8'd0 : phase_q + 8'd1;

        // Prescaler only runs during a session; its wrap cycle is the tick.
        if (running) begin
            if (presc_q == PW'(CLK_HZ - 1)) begin
                presc_d  = '0;
                sec_tick = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end

        if (pump_off) begin
            state_d = ST_IDLE;
            presc_d = '0;
            phase_d = 8'd0;
            min_d   = 7'd0;
            sec_d   = 6'd0;
        end else if (start) begin
            state_d = ST_SPRAY;
            presc_d = '0;
            phase_d = 8'd0;
            min_d   = sel_minutes;
            sec_d   = 6'd0;
        end else if (sec_tick) begin
            if (min_q == 7'd0 && sec_q == 6'd1) begin
                // Natural expiry: last second elapsed, phase is left untouched.
                state_d = ST_IDLE;
                sec_d   = 6'd0;
                done_d  = 1'b1;
            end else begin
                if (sec_q == 6'd0) begin
                    min_d = min_q - 7'd1;
                    sec_d = 6'(SEC_PER_MIN - 1);
                end else begin
                    sec_d = sec_q - 6'd1;
                end
                phase_d = phase_next;
                if (state_q == ST_SPRAY && phase_next == 8'(SPRAY_ON_SEC)) begin
                    state_d = ST_REST;
                end else if (state_q == ST_REST && phase_next == 8'd0) begin
                    state_d = ST_SPRAY;
                end
            end
        end

        pump_drive_d = (state_d == ST_SPRAY);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            phase_q      <= 8'd0;
            min_q        <= 7'd0;
            sec_q        <= 6'd0;
            pump_drive_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            phase_q      <= phase_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            pump_drive_q <= pump_drive_d;
            done_q       <= done_d;
        end
    end

    assign pump_drive   = pump_drive_q;
    assign active       = running;
    assign state        = state_q;
    assign remain_min   = min_q;
    assign remain_sec   = sec_q;
    assign session_done = done_q;

endmodule
